swc: RTL and testbench

Stopwatch controller for a 4-digit chain of 0-9 BCD digit counters. Owns the run/stop/lap state machine, the tick prescaler and the ripple-carry enable generation. It drives one enable per digit and a common digit clear, reads the digit values back, and presents either the live count or a frozen lap value for display.

---
 rtl/swc_pkg.sv | 24 ++
 rtl/swc_tick.sv | 30 +++
 rtl/swc.sv | 118 +++++++++++
 tb/tb_swc.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/swc_pkg.sv
// Shared definitions for the stopwatch controller: state encoding and BCD limits.
package swc_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_LAP  = 2'd2;
    localparam logic [1:0] ST_STOP = 2'd3;

    localparam logic [3:0]  BCD_NINE = 4'd9;
    localparam logic [15:0] BCD_MAX  = 16'h9999;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_LAP  = ST_LAP,
        S_STOP = ST_STOP
    } state_t;

    // Values above nine are deliberately not treated as a carry source.
    function automatic logic is_nine(input logic [3:0] digit);
        return digit == BCD_NINE;
    endfunction

endpackage

// File: rtl/swc_tick.sv
// Tick prescaler: counts 0..TICK_DIV-1 while enabled, holds while disabled,
// and emits a one-cycle tick on the last count.
module swc_tick #(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/swc.sv
// Stopwatch controller: run/stop/lap FSM, ripple-carry digit enables,
// lap freeze register and sticky overflow for a 4-digit BCD chain.
//
// state | meaning
// IDLE  | cleared, prescaler zeroed, waiting for start
// RUN   | counting, display shows live digits
// LAP   | counting, display frozen at captured lap value
// STOP  | halted with partial tick kept; overflow parks here
module swc
    import swc_pkg::*;
#(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic        swc_clk,
    input  logic        swc_rst,
    input  logic        swc_start,
    input  logic        swc_lap,
    input  logic        swc_clear,
    input  logic [15:0] swc_dig_in,
    output logic [3:0]  swc_dig_en,
    output logic        swc_dig_clr,
    output logic [15:0] swc_disp,
    output logic        swc_running,
    output logic        swc_ovf
);

    state_t      state;
    logic [15:0] lap_reg;
    logic        ovf;
    logic        dig_clr;
    logic        active;
    logic        tick;
    logic        tick_clr;
    logic        ovf_hit;
    logic [3:0]  en_chain;

    assign active   = (state == S_RUN) || (state == S_LAP);
    assign tick_clr = (state == S_IDLE) || ((state == S_STOP) && swc_clear);
    assign ovf_hit  = tick && (swc_dig_in == BCD_MAX);

    swc_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (swc_clk),
        .rst  (swc_rst),
        .en   (active),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_comb begin
        en_chain    = '0;
        en_chain[0] = tick;
        for (int i = 1; i < 4; i++) begin
            en_chain[i] = en_chain[i-1] & is_nine(swc_dig_in[4*(i-1) +: 4]);
        end
    end

    // At 9999 the chain would wrap to 0000; suppress it so the count parks.
    assign swc_dig_en = ovf_hit ? 4'b0000 : en_chain;

    always_ff @(posedge swc_clk) begin
        if (swc_rst) begin
            state   <= S_IDLE;
            lap_reg <= '0;
            ovf     <= 1'b0;
            dig_clr <= 1'b0;
        end else begin
            dig_clr <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (swc_clear) begin
                        dig_clr <= 1'b1;
                    end else if (swc_start) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (ovf_hit) begin
                        state <= S_STOP;
                        ovf   <= 1'b1;
                    end else if (swc_start) begin
                        state <= S_STOP;
                    end else if (swc_lap) begin
                        state   <= S_LAP;
                        lap_reg <= swc_dig_in;
                    end
                end
                S_LAP: begin
                    if (ovf_hit) begin
                        state <= S_STOP;
                        ovf   <= 1'b1;
                    end else if (swc_start) begin
                        state <= S_STOP;
                    end else if (swc_lap) begin
                        state <= S_RUN;
                    end
                end
                S_STOP: begin
                    if (swc_clear) begin
                        state   <= S_IDLE;
                        dig_clr <= 1'b1;
                        ovf     <= 1'b0;
                    end else if (swc_start && !ovf) begin
                        state <= S_RUN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign swc_dig_clr = dig_clr;
    assign swc_ovf     = ovf;
    assign swc_running = active;
    assign swc_disp    = (state == S_LAP) ? lap_reg : swc_dig_in;

endmodule

// File: tb/tb_swc.sv
// Bench for swc with TICK_DIV=4 and a behavioural 4-digit BCD chain.
module tb_swc;

    localparam int TICK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        lap = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] digs;
    logic [3:0]  dig_en;
    logic        dig_clr;
    logic [15:0] disp;
    logic        running;
    logic        ovf;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;

    always #5 clk = ~clk;

    swc #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .swc_clk     (clk),
        .swc_rst     (rst),
        .swc_start   (start),
        .swc_lap     (lap),
        .swc_clear   (clear),
        .swc_dig_in  (digs),
        .swc_dig_en  (dig_en),
        .swc_dig_clr (dig_clr),
        .swc_disp    (disp),
        .swc_running (running),
        .swc_ovf     (ovf)
    );

    // Digit counters: hold, increment with 9->0 wrap, clear; plus a bench preload.
    always @(posedge clk) begin
        if (rst) begin
            digs <= 16'h0000;
        end else if (load) begin
            digs <= load_val;
        end else if (dig_clr) begin
            digs <= 16'h0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (dig_en[i]) begin
                    digs[4*i +: 4] <= (digs[4*i +: 4] == 4'd9) ? 4'd0 : digs[4*i +: 4] + 4'd1;
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_val(e.tag, obs, e.val);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic s, input logic l, input logic c);
        start = s;
        lap   = l;
        clear = c;
        @(negedge clk);
        start = 1'b0;
        lap   = 1'b0;
        clear = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic preload(input logic [15:0] v);
        load     = 1'b1;
        load_val = v;
        cyc(1);
        load     = 1'b0;
    endtask

    initial begin
        @(negedge clk);

        // reset values, then first tick and tenth tick
        do_reset();
        push("rst_en", 0); push("rst_run", 0); push("rst_ovf", 0);
        push("rst_clr", 0); push("rst_disp", 16'h0000);
        pop_chk(dig_en); pop_chk(running); pop_chk(ovf); pop_chk(dig_clr); pop_chk(disp);
        push("first_en", 4'b0001); push("first_d", 16'h0001);
        push("d_0010", 16'h0010); push("run_hi", 1);
        pulse(1, 0, 0);
        cyc(3); pop_chk(dig_en);
        cyc(1); pop_chk(disp);
        cyc(36); pop_chk(disp); pop_chk(running);

        // carry ripple through three nines
        do_reset();
        preload(16'h0999);
        push("carry_en", 4'b1111); push("carry_d", 16'h1000);
        pulse(1, 0, 0);
        cyc(3); pop_chk(dig_en);
        cyc(1); pop_chk(disp);

        // stop with cnt=2, hold, resume keeps partial tick
        do_reset();
        push("stop_run", 0); push("hold_d", 16'h0000); push("hold_en", 0);
        push("res_en0", 0); push("res_en1", 4'b0001); push("res_d", 16'h0001);
        pulse(1, 0, 0);
        cyc(1);
        pulse(1, 0, 0);
        pop_chk(running);
        cyc(20); pop_chk(disp); pop_chk(dig_en);
        pulse(1, 0, 0);
        pop_chk(dig_en);
        cyc(1); pop_chk(dig_en);
        cyc(1); pop_chk(disp);

        // lap freeze and release
        do_reset();
        preload(16'h0012);
        push("lap_disp", 16'h0012); push("lap_digs", 16'h0020); push("lap_run", 1);
        push("unlap_disp", 16'h0020);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        cyc(31); pop_chk(disp); pop_chk(digs); pop_chk(running);
        pulse(0, 1, 0);
        pop_chk(disp);

        // overflow at 9999, start ignored, clear recovers
        do_reset();
        preload(16'h9999);
        push("ovf_en", 0); push("ovf_set", 1); push("ovf_run", 0); push("ovf_d", 16'h9999);
        push("ovf_st_run", 0); push("ovf_st_d", 16'h9999); push("ovf_st_f", 1);
        push("ovf_clrp", 1); push("ovf_clr", 0); push("ovf_clr_run", 0);
        push("ovf_clrp_end", 0); push("ovf_clr_d", 16'h0000);
        pulse(1, 0, 0);
        cyc(3); pop_chk(dig_en);
        cyc(1); pop_chk(ovf); pop_chk(running); pop_chk(disp);
        pulse(1, 0, 0);
        cyc(5); pop_chk(running); pop_chk(disp); pop_chk(ovf);
        pulse(0, 0, 1);
        pop_chk(dig_clr); pop_chk(ovf); pop_chk(running);
        cyc(1); pop_chk(dig_clr); pop_chk(disp);

        // start+clear in STOP: clear wins
        do_reset();
        push("sc_clrp", 1); push("sc_run", 0); push("sc_run2", 0);
        pulse(1, 0, 0);
        cyc(2);
        pulse(1, 0, 0);
        pulse(1, 0, 1);
        pop_chk(dig_clr); pop_chk(running);
        cyc(1); pop_chk(running);

        // start+lap in RUN on a tick edge: stop, final increment, no capture
        do_reset();
        preload(16'h0005);
        push("sl_run", 0); push("sl_disp", 16'h0006);
        pulse(1, 0, 0);
        cyc(3);
        pulse(1, 1, 0);
        pop_chk(running); pop_chk(disp);

        // clear in RUN is ignored
        do_reset();
        preload(16'h0007);
        push("cr_clrp", 0); push("cr_run", 1); push("cr_d", 16'h0008);
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        pop_chk(dig_clr); pop_chk(running);
        cyc(3); pop_chk(disp);

        if (sb.size() != 0) check_val("sb_left", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
